bsg_fifo_1w2r_dual_deq: RTL
===========================

Name: bsg_fifo_1w2r_dual_deq

Overview:
- FIFO controller that stores entries in a bsg_mem_2r1w instance. It is the writer and reader of that storage: one enqueue port drives the write port, and the two async read ports expose the two oldest entries.
- The consumer can see head and head+1 in the same cycle, and can dequeue 0, 1 or 2 entries per cycle.
- Used where a downstream stage consumes pairs, e.g. instruction-pair issue or 2-wide packet unpacking.

Parameters:
- width_p, none (must be set), entry data width in bits.
- els_p, none (must be set), entry count; must be ≥2; need not be a power of 2.
- ptr_width_lp, `BSG_SAFE_CLOG2(els_p), read/write pointer width.
- count_width_lp, `BSG_SAFE_CLOG2(els_p+1), occupancy counter width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  enqueue valid.
- data_i  in  width_p  enqueue data.
- ready_o  out  1  space available; enqueue occurs when v_i & ready_o.
- v0_o  out  1  head entry valid.
- data0_o  out  width_p  head entry data.
- v1_o  out  1  second-oldest entry valid.
- data1_o  out  width_p  second-oldest entry data.
- yumi_cnt_i  in  2  entries consumed this cycle: 0, 1 or 2; value 3 is illegal.
- count_o  out  count_width_lp  current occupancy.

Behaviour:
- Interface: one clock, clk_i. reset_i is synchronous and active-high.
- State:
  - rptr_r and wptr_r, both ptr_width_lp wide.
  - count_r, count_width_lp wide.
  - No other FSM; occupancy is derived from count_r.
- Reset: rptr_r=0, wptr_r=0, count_r=0. This gives ready_o=1, v0_o=0, v1_o=0, count_o=0.
- Storage contents are not reset. data0_o and data1_o are don't-care while the matching valid is 0.
- Outputs (combinational from registered state only, with no input-to-output combinational path):
  - ready_o = (count_r != els_p).
  - v0_o = (count_r ≥ 1).
  - v1_o = (count_r ≥ 2).
- Memory hookup:
  - w_v_i = v_i & ready_o; w_addr_i = wptr_r.
  - r0_addr_i = rptr_r; r0_v_i = v0_o.
  - r1_addr_i = rptr_r+1 with wrap; r1_v_i = v1_o.
  - read_write_same_addr_p=0. The gating above guarantees a valid read never targets the entry being written.
- Latency: an enqueued entry becomes visible on v0_o or v1_o on the cycle after the enqueue. There is no fall-through.
- Dequeue:
  - Consumed count deq = yumi_cnt_i.
  - Legal only if deq ≤ count_r (deq=1 requires v0_o; deq=2 requires v1_o).
  - On dequeue, rptr_r advances by deq.
- Pointer wrap: advancing by k computes (ptr+k) and subtracts els_p if the result is ≥ els_p. This must be correct for non-power-of-2 els_p, including a +2 step from els_p-1, which lands on 1.
- Occupancy update: count_r_next = count_r + enq - deq.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle are both honoured.
  - When full, ready_o=0 even if a dequeue happens that cycle. No bypass of the full condition.
  - When empty, an enqueue still yields v0_o=0 in the same cycle.
- Reset mid-operation: any contents are discarded and all state returns to reset values on the next edge. Inputs are ignored in the reset cycle.
- Simulation-only assertions (translate_off), checked on negedge when not in reset, each raising $error:
  - yumi_cnt_i==3.
  - yumi_cnt_i > count_r.
  - v_i asserted while ready_o=0 is legal, and the entry is dropped by design; the producer must hold v_i.

Test Plan:
- Reset, then check outputs: ready_o=1, v0_o=0, v1_o=0, count_o=0.
- els_p=4, enqueue A1,A2,A3,A4 on consecutive cycles with yumi_cnt_i=0 -> ready_o=0 after the 4th edge, count_o=4, data0_o=A1, data1_o=A2. A 5th v_i is refused and count stays 4.
- From full (A1..A4): yumi_cnt_i=2 -> next cycle data0_o=A3, data1_o=A4, count_o=2. Then yumi_cnt_i=1 -> data0_o=A4, v1_o=0.
- els_p=3, drive ptrs to rptr_r=2 with 2 entries B1 (addr 2) and B2 (addr 0). Enqueue B3 and yumi 2 in the same cycle -> rptr_r=1, data0_o=B3, count_o=1. This checks the non-power-of-2 wrap.
- Empty FIFO: enqueue C1 -> v0_o stays 0 that cycle, then v0_o=1 and data0_o=C1 next cycle. The same-address assertion must not fire.
- Mid-stream reset with 3 entries held -> after the edge count_o=0, v0_o=0, ready_o=1. A subsequent enqueue of D1 appears as data0_o=D1.

Source files
------------

// File: rtl/bsg_fifo_1w2r_dual_deq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bsg_fifo_1w2r_dual_deq (with helper storage bsg_mem_2r1w)     |
// | Purpose  : FIFO with one enqueue port that exposes its two oldest        |
// |            entries at once and retires 0, 1 or 2 of them per cycle.      |
// | Ports    : clk_i, reset_i          clock / synchronous active-high reset |
// |            v_i, data_i, ready_o    enqueue handshake (v_i & ready_o)     |
// |            v0_o, data0_o           head entry                            |
// |            v1_o, data1_o           head+1 entry                          |
// |            yumi_cnt_i              entries consumed this cycle (0..2)    |
// |            count_o                 current occupancy                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

// Storage: one synchronous write port, two asynchronous read ports.
// Contents are never reset; reads of an invalid port return zero.
module bsg_mem_2r1w #(
  parameter int width_p                = 8,
  parameter int els_p                  = 4,
  parameter int read_write_same_addr_p = 0,
  parameter int addr_width_lp          = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r0_v_i,
  input  logic [addr_width_lp-1:0] r0_addr_i,
  output logic [width_p-1:0]       r0_data_o,
  input  logic                     r1_v_i,
  input  logic [addr_width_lp-1:0] r1_addr_i,
  output logic [width_p-1:0]       r1_data_o
);

  logic [width_p-1:0] r_mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      r_mem[w_addr_i] <= w_data_i;
    end
  end

  assign r0_data_o = r0_v_i ? r_mem[r0_addr_i] : '0;
  assign r1_data_o = r1_v_i ? r_mem[r1_addr_i] : '0;

`ifndef SYNTHESIS
  // Without read/write bypass, a valid read must never hit the slot being written.
  always @(negedge clk_i) begin
    if (read_write_same_addr_p == 0) begin
      if (w_v_i && r0_v_i && (w_addr_i == r0_addr_i))
        $error("bsg_mem_2r1w: read port 0 targets the address being written");
      if (w_v_i && r1_v_i && (w_addr_i == r1_addr_i))
        $error("bsg_mem_2r1w: read port 1 targets the address being written");
    end
  end
`endif

endmodule

module bsg_fifo_1w2r_dual_deq #(
  parameter int width_p        = 8,
  parameter int els_p          = 4,
  parameter int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int count_width_lp = ((els_p + 1) > 1) ? $clog2(els_p + 1) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        data_i,
  output logic                      ready_o,
  output logic                      v0_o,
  output logic [width_p-1:0]        data0_o,
  output logic                      v1_o,
  output logic [width_p-1:0]        data1_o,
  input  logic [1:0]                yumi_cnt_i,
  output logic [count_width_lp-1:0] count_o
);

  localparam logic [count_width_lp-1:0] c_els_count = count_width_lp'(els_p);
  localparam logic [ptr_width_lp:0]     c_els_wide  = (ptr_width_lp + 1)'(els_p);

  logic [ptr_width_lp-1:0]   r_rptr;
  logic [ptr_width_lp-1:0]   r_wptr;
  logic [count_width_lp-1:0] r_count;

  logic                      w_enq;
  logic [ptr_width_lp-1:0]   w_rptr_plus1;
  logic [ptr_width_lp-1:0]   w_rptr_next;
  logic [ptr_width_lp-1:0]   w_wptr_next;
  logic [count_width_lp-1:0] w_count_next;

  // Modular advance for any els_p. One extra bit holds ptr+k (at most
  // els_p+1), so a single conditional subtract lands back in range, e.g.
  // els_p-1 advanced by 2 becomes 1.
  function automatic logic [ptr_width_lp-1:0] f_advance(
    input logic [ptr_width_lp-1:0] ptr,
    input logic [1:0]              k
  );
    logic [ptr_width_lp:0] sum;
    sum = {1'b0, ptr} + (ptr_width_lp + 1)'(k);
    if (sum >= c_els_wide) begin
      sum = sum - c_els_wide;
    end
    return sum[ptr_width_lp-1:0];
  endfunction

  // Status outputs depend on registered occupancy only.
  assign ready_o = (r_count != c_els_count);
  assign v0_o    = (r_count >= count_width_lp'(1));
  assign v1_o    = (r_count >= count_width_lp'(2));
  assign count_o = r_count;

  assign w_enq        = v_i & ready_o;
  assign w_rptr_plus1 = f_advance(r_rptr, 2'd1);
  assign w_rptr_next  = f_advance(r_rptr, yumi_cnt_i);
  assign w_wptr_next  = f_advance(r_wptr, {1'b0, w_enq});
  assign w_count_next = r_count + count_width_lp'(w_enq) - count_width_lp'(yumi_cnt_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_rptr  <= w_rptr_next;
      r_wptr  <= w_wptr_next;
      r_count <= w_count_next;
    end
  end

  // Writes only happen into free slots and reads only from occupied ones,
  // so the no-bypass storage is safe.
  bsg_mem_2r1w #(
    .width_p               (width_p),
    .els_p                 (els_p),
    .read_write_same_addr_p(0),
    .addr_width_lp         (ptr_width_lp)
  ) u_mem (
    .clk_i    (clk_i),
    .w_v_i    (w_enq),
    .w_addr_i (r_wptr),
    .w_data_i (data_i),
    .r0_v_i   (v0_o),
    .r0_addr_i(r_rptr),
    .r0_data_o(data0_o),
    .r1_v_i   (v1_o),
    .r1_addr_i(w_rptr_plus1),
    .r1_data_o(data1_o)
  );

`ifndef SYNTHESIS
  // An enqueue while full is legal and simply dropped; the producer holds v_i.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (yumi_cnt_i == 2'd3)
        $error("bsg_fifo_1w2r_dual_deq: yumi_cnt_i of 3 is illegal");
      if (32'(yumi_cnt_i) > 32'(r_count))
        $error("bsg_fifo_1w2r_dual_deq: dequeue exceeds occupancy");
    end
  end
`endif

endmodule
`default_nettype wire
